// File: rtl/sin_lockin_pkg.sv
// sin_lockin_pkg: shared widths, FSM state type and result scaling for the lock-in accumulator
// Optional SIN_LOCKIN_ROUND_EN: round half up with positive saturation instead of floor
package sin_lockin_pkg;
  localparam int SL_MPR = 14;
  localparam int SL_ADW = 14;
  localparam int SL_WLW = 16;
  localparam int SL_OUTW = 32;
  localparam int ACCW = SL_MPR + SL_ADW + SL_WLW;
  localparam int DROPW = ACCW - SL_OUTW;
  typedef enum logic {IDLE, ACC} state_t;
  function automatic logic [SL_OUTW-1:0] scale(input logic signed [ACCW-1:0] a);
`ifdef SIN_LOCKIN_ROUND_EN
    logic [ACCW:0] r;
    r = {a[ACCW-1], a} + (ACCW+1)'(2 ** (DROPW - 1));
    // differing top bits mean the half-LSB add carried past the positive range
    return (r[ACCW] != r[ACCW-1]) ? {1'b0, {(SL_OUTW-1){1'b1}}} : r[ACCW-1:DROPW];
`else
    return a[ACCW-1:DROPW];
`endif
  endfunction
endpackage

// File: rtl/sin_lockin_if.sv
// sin_lockin_if: result stream with valid/ready and sticky overrun
// master: drives result_o, result_valid_o, overrun_o; samples result_ready_i
// slave: the consumer side of the same signals
interface sin_lockin_if #(parameter int OUTW = 32);
  logic [OUTW-1:0] result_o;
  logic result_valid_o;
  logic result_ready_i;
  logic overrun_o;
  modport master(output result_o, result_valid_o, overrun_o, input result_ready_i);
  modport slave(input result_o, result_valid_o, overrun_o, output result_ready_i);
endinterface

// File: rtl/sin_lockin_mac.sv
// sin_lockin_mac: two-stage multiply/accumulate, frozen while clken is low
// Ports: clk, reset_n (async active-low), clken, fsin_i/adc_i samples, qual_i/first_i/last_i
// sample flags; acc_o running window sum, done_o high while acc_o holds a completed window
module sin_lockin_mac
  import sin_lockin_pkg::*;
#(
  parameter int MPR = SL_MPR,
  parameter int ADW = SL_ADW
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clken,
  input  logic signed [MPR-1:0]  fsin_i,
  input  logic signed [ADW-1:0]  adc_i,
  input  logic                   qual_i,
  input  logic                   first_i,
  input  logic                   last_i,
  output logic signed [ACCW-1:0] acc_o,
  output logic                   done_o
);
  logic signed [MPR+ADW-1:0] prod_q;
  logic v1_q, first1_q, last1_q, done_q;
  logic signed [ACCW-1:0] acc_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prod_q <= '0;
      v1_q <= 1'b0;
      first1_q <= 1'b0;
      last1_q <= 1'b0;
      acc_q <= '0;
      done_q <= 1'b0;
    end else if (clken) begin
      prod_q <= (MPR+ADW)'(fsin_i) * (MPR+ADW)'(adc_i);
      v1_q <= qual_i;
      first1_q <= first_i;
      last1_q <= last_i;
      // the first product of a window overwrites, which also drops any aborted partial sum
      if (v1_q) acc_q <= first1_q ? ACCW'(prod_q) : acc_q + ACCW'(prod_q);
      done_q <= v1_q & last1_q;
    end
  assign acc_o = acc_q;
  assign done_o = done_q;
endmodule

// File: rtl/sin_lockin_acc.sv
// sin_lockin_acc: lock-in demodulator, integrates fsin*adc over programmable windows
// Ports: clk, reset_n (async active-low), clken, fsin_i, sin_valid_i, adc_i, enable_i,
// win_len_i (latched per window), res_if (result stream master), busy_o (window in progress)
// Optional SIN_LOCKIN_ROUND_EN: rounded, saturating result scaling (see sin_lockin_pkg)
module sin_lockin_acc
  import sin_lockin_pkg::*;
#(
  parameter int MPR = SL_MPR,
  parameter int ADW = SL_ADW,
  parameter int WLW = SL_WLW,
  parameter int OUTW = SL_OUTW
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic signed [MPR-1:0] fsin_i,
  input  logic                  sin_valid_i,
  input  logic signed [ADW-1:0] adc_i,
  input  logic                  enable_i,
  input  logic [WLW-1:0]        win_len_i,
  sin_lockin_if.master          res_if,
  output logic                  busy_o
);
  state_t state_q;
  logic [WLW-1:0] cnt_q, len_q;
  logic busy_q, qual, first, last, done, load, accept;
  logic signed [ACCW-1:0] acc;
  logic [OUTW-1:0] result_q, result_d;
  logic valid_q, valid_d, overrun_q, overrun_d;
  assign qual = sin_valid_i & (state_q == ACC);
  assign first = cnt_q == '0;
  assign last = cnt_q == len_q - WLW'(1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      cnt_q <= '0;
      len_q <= '0;
    end else if (clken) begin
      if (state_q == IDLE) begin
        if (enable_i && win_len_i != '0) begin
          state_q <= ACC;
          busy_q <= 1'b1;
          len_q <= win_len_i;
          cnt_q <= '0;
        end
      end else begin
        if (sin_valid_i) cnt_q <= last ? '0 : cnt_q + WLW'(1);
        if (!enable_i) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end else if (sin_valid_i && last) begin
          // back-to-back windows: relatch length, or stop if it was set to zero
          if (win_len_i == '0) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
          end else len_q <= win_len_i;
        end
      end
    end
  sin_lockin_mac #(.MPR(MPR), .ADW(ADW)) u_mac (
    .clk(clk),
    .reset_n(reset_n),
    .clken(clken),
    .fsin_i(fsin_i),
    .adc_i(adc_i),
    .qual_i(qual),
    .first_i(first),
    .last_i(last),
    .acc_o(acc),
    .done_o(done)
  );
  // result handshake runs every cycle; only the load of a new window waits for clken
  always_comb begin
    load = clken & done;
    accept = valid_q & res_if.result_ready_i;
    valid_d = load | (valid_q & ~accept);
    overrun_d = ~accept & (overrun_q | (load & valid_q));
    result_d = load ? scale(acc) : result_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      result_q <= '0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
    end
  assign res_if.result_o = result_q;
  assign res_if.result_valid_o = valid_q;
  assign res_if.overrun_o = overrun_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_sin_lockin_acc.sv
// tb_sin_lockin_acc: scoreboard bench for sin_lockin_acc
module tb_sin_lockin_acc;
  logic clk = 1'b0, reset_n = 1'b0, clken = 1'b0, sin_valid = 1'b0, enable = 1'b0, busy;
  logic signed [13:0] fsin = '0, adc = '0;
  logic [15:0] win_len = '0;
  int n_cmp = 0, n_bad = 0, cnt = 0, wl = 1, npush = 0;
  longint sum = 0;
  longint exp_q[$];
  sin_lockin_if #(.OUTW(32)) res_if();
  sin_lockin_acc dut (
    .clk(clk),
    .reset_n(reset_n),
    .clken(clken),
    .fsin_i(fsin),
    .sin_valid_i(sin_valid),
    .adc_i(adc),
    .enable_i(enable),
    .win_len_i(win_len),
    .res_if(res_if),
    .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint tb_scale(input longint s);
`ifdef SIN_LOCKIN_ROUND_EN
    longint r;
    r = (s + 2048) >>> 12;
    return (r > 64'sd2147483647) ? 64'sd2147483647 : r;
`else
    return s >>> 12;
`endif
  endfunction
  always @(negedge clk)
    if (reset_n && res_if.result_valid_o && res_if.result_ready_i) begin
      if (exp_q.size() == 0) chk("unexpected_result", 64'(res_if.result_valid_o), 64'sd0);
      else chk("result", 64'($signed(res_if.result_o)), exp_q.pop_front());
    end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input int len);
    enable = 1'b1;
    win_len = 16'(len);
    clken = 1'b1;
    sin_valid = 1'b0;
    cyc();
    wl = len;
    sum = 0;
    cnt = 0;
  endtask
  task automatic feed(input logic signed [13:0] f, input logic signed [13:0] a, input logic ck, input logic sv);
    fsin = f;
    adc = a;
    clken = ck;
    sin_valid = sv;
    cyc();
    if (ck && sv) begin
      sum += longint'(f) * longint'(a);
      cnt++;
      if (cnt == wl) begin
        exp_q.push_back(tb_scale(sum));
        npush++;
        sum = 0;
        cnt = 0;
      end
    end
  endtask
  task automatic stop_drain();
    enable = 1'b0;
    sin_valid = 1'b0;
    clken = 1'b1;
    cyc();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    chk("drain", 64'(exp_q.size()), 64'sd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    res_if.result_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 64'(res_if.result_o), 64'sd0);
    chk("rst_valid", 64'(res_if.result_valid_o), 64'sd0);
    chk("rst_overrun", 64'(res_if.overrun_o), 64'sd0);
    chk("rst_busy", 64'(busy), 64'sd0);
    reset_n = 1'b1;
    cyc();
    start(4);
    chk("busy_acc", 64'(busy), 64'sd1);
    for (int i = 0; i < 4; i++) feed(14'sd8191, 14'sd8191, 1'b1, 1'b1);
    enable = 1'b0;
    sin_valid = 1'b0;
    @(negedge clk);
    chk("lat_e0", 64'(res_if.result_valid_o), 64'sd0);
    @(negedge clk);
    chk("lat_e1", 64'(res_if.result_valid_o), 64'sd0);
    chk("busy_off", 64'(busy), 64'sd0);
    @(negedge clk);
    chk("lat_e2", 64'(res_if.result_valid_o), 64'sd1);
    @(negedge clk);
    chk("lat_e3", 64'(res_if.result_valid_o), 64'sd0);
    cyc();
    chk("drain4", 64'(exp_q.size()), 64'sd0);
    start(1);
    for (int i = 0; i < 6; i++) feed(14'sh2000, 14'sd8191, 1'b1, 1'b1);
    stop_drain();
    chk("b2b_no_overrun", 64'(res_if.overrun_o), 64'sd0);
    start(1);
    for (int i = 0; i < 2; i++) feed(14'sd1, 14'sd2048, 1'b1, 1'b1);
    stop_drain();
    start(300);
    for (int i = 0; i < 300; i++) feed(14'sh2000, 14'sh2000, 1'b1, 1'b1);
    stop_drain();
    start(8);
    npush = 0;
    for (int i = 0; i < 400 && npush < 3; i++)
      feed(14'($urandom), 14'($urandom), 1'($urandom), 1'($urandom));
    chk("gated_windows", 64'(npush), 64'sd3);
    stop_drain();
    res_if.result_ready_i = 1'b0;
    start(2);
    feed(14'sd100, 14'sd200, 1'b1, 1'b1);
    feed(14'sd300, 14'sd400, 1'b1, 1'b1);
    feed(-14'sd5000, 14'sd7000, 1'b1, 1'b1);
    feed(14'sd1234, -14'sd4321, 1'b1, 1'b1);
    enable = 1'b0;
    sin_valid = 1'b0;
    repeat (5) cyc();
    chk("ovr_valid", 64'(res_if.result_valid_o), 64'sd1);
    chk("ovr_flag", 64'(res_if.overrun_o), 64'sd1);
    void'(exp_q.pop_front());
    chk("ovr_result", 64'($signed(res_if.result_o)), exp_q[0]);
    res_if.result_ready_i = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    res_if.result_ready_i = 1'b0;
    @(negedge clk);
    chk("ovr_valid_clr", 64'(res_if.result_valid_o), 64'sd0);
    chk("ovr_flag_clr", 64'(res_if.overrun_o), 64'sd0);
    chk("ovr_drain", 64'(exp_q.size()), 64'sd0);
    res_if.result_ready_i = 1'b1;
    cyc();
    start(8);
    for (int i = 0; i < 3; i++) feed(14'sd1000, 14'sd1000, 1'b1, 1'b1);
    enable = 1'b0;
    cyc();
    sin_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'sd0);
    repeat (4) cyc();
    chk("abort_no_valid", 64'(res_if.result_valid_o), 64'sd0);
    start(8);
    for (int i = 0; i < 8; i++) feed(14'($urandom), 14'($urandom), 1'b1, 1'b1);
    stop_drain();
    res_if.result_ready_i = 1'b0;
    start(1);
    feed(14'sd1000, 14'sd1000, 1'b1, 1'b1);
    enable = 1'b0;
    sin_valid = 1'b0;
    repeat (4) cyc();
    chk("pre_rst_valid", 64'(res_if.result_valid_o), 64'sd1);
    start(4);
    feed(14'sd77, 14'sd99, 1'b1, 1'b1);
    feed(14'sd77, 14'sd99, 1'b1, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_result", 64'(res_if.result_o), 64'sd0);
    chk("mid_rst_valid", 64'(res_if.result_valid_o), 64'sd0);
    chk("mid_rst_overrun", 64'(res_if.overrun_o), 64'sd0);
    chk("mid_rst_busy", 64'(busy), 64'sd0);
    exp_q.delete();
    enable = 1'b0;
    sin_valid = 1'b0;
    cyc();
    reset_n = 1'b1;
    res_if.result_ready_i = 1'b1;
    cyc();
    start(2);
    feed(-14'sd3000, 14'sd2500, 1'b1, 1'b1);
    feed(14'sd4000, 14'sd4000, 1'b1, 1'b1);
    stop_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sin_lockin_acc.md
# sin_lockin_acc

Lock-in demodulation stage placed directly downstream of the 400 kHz NCO. It multiplies each valid NCO sine sample by the coincident signed ADC sample and integrates the products over a programmable window of qualified samples. It then presents one correlation result per window on a valid/ready output for the acquisition path.

## Interface
Parameters:
- MPR, 14, NCO sine width (signed two's complement)
- ADW, 14, ADC sample width (signed two's complement)
- WLW, 16, window-length width
- OUTW, 32, output result width
- ACCW is derived, never overridden: MPR+ADW+WLW = 44

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- clken  in  1  clock enable shared with the NCO
- fsin_i  in  MPR  NCO sine sample
- sin_valid_i  in  1  NCO output valid
- adc_i  in  ADW  ADC sample, aligned to fsin_i
- enable_i  in  1  run windows while high
- win_len_i  in  WLW  samples per window, latched at window start
- result_o  out  OUTW  scaled window sum
- result_valid_o  out  1  result available
- result_ready_i  in  1  consumer accepts result
- overrun_o  out  1  a result was overwritten before it was accepted
- busy_o  out  1  state is ACC

## Operation
- FSM states:
  - IDLE -> ACC when enable_i=1 and win_len_i!=0. On this transition: latch len_q=win_len_i, clear cnt.
  - ACC -> IDLE when enable_i=0. The partial window is discarded and no result is produced.
- Qualified sample: clken & sin_valid_i & state==ACC.
- Stage 1 (registered): prod = signed fsin_i * signed adc_i, MPR+ADW bits. A first-of-window flag travels with it.
- Stage 2 (registered): acc <= first ? sext(prod) : acc + sext(prod), at ACCW bits. Overflow is impossible by construction.
- cnt increments on each qualified sample.
- Window end: when cnt reaches len_q-1, the last flag travels with the product.
  - If enable_i is still high, relatch len_q from win_len_i and start the next window back-to-back with no lost samples.
  - If win_len_i is now 0, go to IDLE.
- When the last product is accumulated, result_o <= scale(acc_final) and result_valid_o <= 1.
- Scaling: take acc[ACCW-1 -: OUTW], which drops the low ACCW-OUTW = 12 bits (floor).
- Handshake:
  - result_valid_o and result_o hold until result_valid_o & result_ready_i. Valid clears in the cycle after acceptance.
  - A new result arriving while valid is still unaccepted overwrites result_o and sets overrun_o.
  - A new result in the same cycle as acceptance loads the new value, keeps valid at 1, and does not set overrun_o.
- overrun_o is sticky. It is cleared on the accept cycle or by reset.
- clken=0 freezes the FSM, cnt and both pipeline stages. The output handshake and overrun logic run regardless of clken.
- Reset values: result_o=0, result_valid_o=0, overrun_o=0, busy_o=0, state IDLE, cnt=0, acc=0, pipeline flags=0. Reset mid-window discards everything.

## Timing
- Latency: result_valid_o rises 2 enabled clock edges after the edge that sampled the last qualified input.
- Throughput: one qualified sample per cycle.
- enable_i falling while the last product is still in the pipeline: that window still completes. Only products whose window's last sample had not yet been taken are discarded.

## Configuration
- SIN_LOCKIN_ROUND_EN undefined: scaling is floor truncation as above.
- SIN_LOCKIN_ROUND_EN defined:
  - Add 2^(ACCW-OUTW-1) before dropping the low bits (round half up).
  - Saturate to +(2^(OUTW-1)-1) if the addition overflows the positive range.
  - Latency is unchanged.

## Structure
- Package sin_lockin_pkg holds:
  - the state enum (IDLE, ACC)
  - ACCW, and the drop-width constant ACCW-OUTW
  - the scale/round function
- Sub-module sin_lockin_mac holds:
  - the stage-1 multiplier and stage-2 accumulator, with first/last flags
  - clken gating
- The top level holds the FSM, counter and output handshake.

## Test plan
- win_len=4, fsin=+8191, adc=+8191 for 4 samples, ready=1 -> acc=268369924; result_o=65520; valid for exactly 1 cycle, 2 cycles after the 4th sample.
- win_len=1, fsin=-8192, adc=+8191 -> result_o=-16382. Windows run back-to-back every qualified cycle with no gaps.
- win_len=1, fsin=1, adc=2048 -> result_o=0 without SIN_LOCKIN_ROUND_EN and 1 with it. fsin=+8191, adc=+8191 with win_len=65535 and rounding -> saturation is never hit; result matches the model.
- win_len=8 with clken toggling 1/0 and sin_valid_i low in random cycles -> the result equals the sum over qualified samples only, and cnt is frozen during gaps.
- ready=0 across two completed windows -> result_o shows the second window and overrun_o=1. One ready cycle -> valid=0 and overrun_o=0 next cycle.
- enable_i dropped after 3 of 8 samples -> no result_valid_o, busy_o=0 next cycle. Re-enable -> a clean 8-sample window. reset_n pulsed mid-window -> all outputs 0 immediately.
